// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, 8N1 frame
// constants and the baud divisor derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clock cycles per line bit; integer division truncates toward zero.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit. clear holds it at zero between frames.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last_s;

  // Next count: wrap at the bit boundary, hold at zero while cleared.
  always_comb begin
    cnt_d     = cnt_q;
    at_last_s = (cnt_q == LAST);
    if (clear) begin
      cnt_d = '0;
    end else if (at_last_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = at_last_s & ~clear;

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from a uart_fifo read port
// (q valid one cycle after rdreq) and serialises them LSB first.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_q,
  input  logic       fifo_rdempty,
  output logic       fifo_rdreq,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_drain: CLK_HZ/BAUD must be at least 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        rdreq_q, rdreq_d;
  logic        busy_q, busy_d;
  logic        baud_clear_s;
  logic        baud_tick_s;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear_s),
    .tick (baud_tick_s)
  );

  // Next-state, shift register and registered-output decode.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    baud_clear_s = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_rdempty) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // q for the pop issued in FETCH is valid in this cycle.
        state_d   = START;
        shift_d   = fifo_q;
        bit_idx_d = 3'd0;
      end
      START: begin
        baud_clear_s = 1'b0;
        if (baud_tick_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        baud_clear_s = 1'b0;
        if (baud_tick_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        baud_clear_s = 1'b0;
        if (baud_tick_s) begin
          if (fifo_rdempty) begin
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    rdreq_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      rdreq_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rdreq_q   <= rdreq_d;
      busy_q    <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rdreq = rdreq_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed and randomized bench for uart_tx_drain with a queue-based FIFO and
// an expected-waveform reference built frame by frame.
module tb_uart_tx_drain;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_q;
  logic       fifo_rdempty;
  logic       fifo_rdreq;
  logic       tx;
  logic       busy;

  uart_tx_drain #(.CLK_HZ(100), .BAUD(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_q      (fifo_q),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq  (fifo_rdreq),
    .tx          (tx),
    .busy        (busy)
  );

  localparam int CPB = 10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fifo_mem[$];
  logic       exp_line[$];
  int         rq_cycles[$];
  logic       hide;
  logic       exp_tx, exp_rq, exp_busy, free, pending;
  int         n_chk, n_fail, cyc_n, rq_count, rd_empty_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc_n);
    end
  endtask

  task automatic upd_empty();
    fifo_rdempty = (fifo_mem.size() == 0) || hide;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem.push_back(b);
    upd_empty();
  endtask

  // One full 8N1 line image for byte b, one entry per clock.
  task automatic add_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) exp_line.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) exp_line.push_back(b[k]);
    for (int i = 0; i < CPB; i++) exp_line.push_back(1'b1);
  endtask

  // Advance one clock, play the FIFO, update the reference and compare.
  task automatic cyc();
    logic rq_before, empty_before, rst_before;
    rq_before    = fifo_rdreq;
    empty_before = fifo_rdempty;
    rst_before   = rst;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rq_before === 1'b1) begin
      if (fifo_mem.size() == 0) rd_empty_ev++;
      else fifo_q = fifo_mem.pop_front();
    end
    upd_empty();
    if (rst_before) begin
      exp_line.delete();
      pending  = 1'b0;
      exp_tx   = 1'b1;
      exp_rq   = 1'b0;
      exp_busy = 1'b0;
      free     = 1'b1;
    end else begin
      exp_rq = free && !empty_before;
      if (exp_rq) begin
        exp_tx   = 1'b1;
        exp_busy = 1'b1;
        exp_line.push_back(1'b1);
        pending  = 1'b1;
      end else if (exp_line.size() > 0) begin
        exp_tx   = exp_line.pop_front();
        exp_busy = 1'b1;
        if (pending) begin
          add_frame(fifo_q);
          pending = 1'b0;
        end
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      free = !exp_rq && (exp_line.size() == 0);
    end
    if (fifo_rdreq === 1'b1) begin
      rq_count++;
      rq_cycles.push_back(cyc_n);
    end
    check("tx", tx, exp_tx);
    check("rdreq", fifo_rdreq, exp_rq);
    check("busy", busy, exp_busy);
  endtask

  task automatic run_until_idle(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      cyc();
      done = (fifo_mem.size() == 0) && (exp_line.size() == 0) && !exp_busy && (busy === 1'b0);
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic wait_fetch(input int limit);
    for (int i = 0; i < limit && fifo_rdreq !== 1'b1; i++) cyc();
    check("fetch_seen", fifo_rdreq, 1'b1);
  endtask

  initial begin
    int base;
    n_chk = 0; n_fail = 0; cyc_n = 0; rq_count = 0; rd_empty_ev = 0;
    free = 1'b1; pending = 1'b0;
    hide = 1'b0; fifo_q = 8'h00; rst = 1'b1;
    push(8'hA5);

    // Reset with a non-empty FIFO, then the single 0xA5 frame.
    repeat (3) cyc();
    check("rst_no_pulse", rq_count, 0);
    rst = 1'b0;
    cyc();
    check("rdreq_after_rst", fifo_rdreq, 1'b1);
    run_until_idle(300);
    check("a5_pulses", rq_count, 1);

    // Back-to-back 0x00 then 0xFF: a FETCH every 102 cycles.
    rq_count = 0;
    rq_cycles.delete();
    push(8'h00);
    push(8'hFF);
    run_until_idle(400);
    check("b2b_pulses", rq_count, 2);
    if (rq_cycles.size() == 2) check("b2b_spacing", rq_cycles[1] - rq_cycles[0], 102);
    else check("b2b_spacing", rq_cycles.size(), 2);

    // Long empty stretch.
    base = rq_count;
    repeat (1000) cyc();
    check("empty_no_pulse", rq_count, base);

    // Reset in the middle of data bit 3 of 0x3C.
    push(8'h3C);
    wait_fetch(20);
    repeat (1 + CPB + 3 * CPB + CPB / 2) cyc();
    check("bit3_level", tx, 1'b1);
    base = rq_count;
    rst = 1'b1;
    cyc();
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (30) cyc();
    check("abort_no_pulse", rq_count, base);
    push(8'h5A);
    run_until_idle(300);

    // FIFO reports empty on the final stop cycle: go idle without a pop.
    push(8'h81);
    push(8'h42);
    wait_fetch(20);
    for (int i = 0; i < 200 && !(free && exp_busy); i++) cyc();
    check("last_stop_found", free && exp_busy, 1'b1);
    hide = 1'b1;
    upd_empty();
    base = rq_count;
    repeat (20) cyc();
    check("late_empty_pulses", rq_count, base);
    check("late_empty_busy", busy, 1'b0);
    hide = 1'b0;
    upd_empty();
    run_until_idle(300);

    // Random bytes arriving with random gaps.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 150)) cyc();
    end
    run_until_idle(3000);

    check("read_while_empty", rd_empty_ev, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
